conv_window_feeder: RTL and testbench

//  Parametrised successor to the layer-1 picture feeder. Streams convolution taps from banked picture RAM and weight RAM

---
 rtl/conv_window_feeder.sv | 192 +++++++++++++++++++
 tb/tb_conv_window_feeder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_window_feeder.sv
// Streams convolution taps from banked picture RAM and weight RAM into a PAR_H x PAR_L conv
// array, walking channels and filter taps with zero padding and valid/ready backpressure.
module conv_window_feeder #(
    parameter int BITS     = 16,
    parameter int CH_NUM   = 1,
    parameter int PAR_H    = 4,
    parameter int PAR_L    = 4,
    parameter int PIC_LEN  = 100,
    parameter int PIC_HEI  = 252,
    parameter int FILT     = 5,
    parameter int STRIDE_H = 4,
    parameter int STRIDE_L = 4,
    parameter int PAD      = 0,
    parameter int ADDR_W   = 15,
    parameter int W_BITS   = 64,
    parameter int WA_W     = 5
) (
    input  logic                              clk_in,
    input  logic                              rst_n,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic                              mem_en,
    output logic [PAR_H*PAR_L*ADDR_W-1:0]     mem_addr,
    input  logic [PAR_H*PAR_L*BITS-1:0]       mem_data,
    output logic [WA_W-1:0]                   w_addr,
    input  logic [W_BITS-1:0]                 w_data,
    output logic [PAR_H*PAR_L*BITS-1:0]       map,
    output logic [W_BITS-1:0]                 weight,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [PAR_H*PAR_L-1:0]            lane_mask,
    output logic                              first_tap,
    output logic                              last_tap,
    output logic                              last
);

    localparam int LANES = PAR_H * PAR_L;
    localparam int OUT_H = (PIC_HEI + 2 * PAD - FILT) / STRIDE_H + 1;
    localparam int OUT_L = (PIC_LEN + 2 * PAD - FILT) / STRIDE_L + 1;
    localparam int TR    = (OUT_H + PAR_H - 1) / PAR_H;
    localparam int TC    = (OUT_L + PAR_L - 1) / PAR_L;
    localparam int F_W   = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int C_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int TR_W  = (TR > 1) ? $clog2(TR) : 1;
    localparam int TC_W  = (TC > 1) ? $clog2(TC) : 1;

    localparam logic [F_W-1:0]  F_MAX  = F_W'(FILT - 1);
    localparam logic [C_W-1:0]  C_MAX  = C_W'(CH_NUM - 1);
    localparam logic [TR_W-1:0] TR_MAX = TR_W'(TR - 1);
    localparam logic [TC_W-1:0] TC_MAX = TC_W'(TC - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e          state_q;
    logic [F_W-1:0]  oh_q, ol_q;
    logic [C_W-1:0]  c_q;
    logic [TC_W-1:0] tcol_q;
    logic [TR_W-1:0] trow_q;
    logic            done_q;

    logic             adv, issue, tap_end, frame_end;
    logic [LANES-1:0] oob, lmask;

    logic             s1_valid_q, s1_first_q, s1_tap_end_q, s1_last_q;
    logic [LANES-1:0] s1_zero_q, s1_mask_q;

    logic                  out_valid_q, first_tap_q, last_tap_q, last_q;
    logic [LANES*BITS-1:0] map_q;
    logic [W_BITS-1:0]     weight_q;
    logic [LANES-1:0]      lane_mask_q;

    assign adv       = !(out_valid_q && !out_ready);
    assign issue     = adv && (state_q == StRun);
    assign mem_en    = adv && (state_q != StIdle);
    assign tap_end   = (oh_q == F_MAX) && (ol_q == F_MAX) && (c_q == C_MAX);
    assign frame_end = tap_end && (tcol_q == TC_MAX) && (trow_q == TR_MAX);

    // Per-lane picture coordinates; signed so that padded taps go negative.
    for (genvar j = 0; j < PAR_H; j++) begin : g_row
        for (genvar k = 0; k < PAR_L; k++) begin : g_col
            localparam int N = j * PAR_L + k;
            int orow, ocol, r, q;

            assign orow = int'(trow_q) * PAR_H + j;
            assign ocol = int'(tcol_q) * PAR_L + k;
            assign r    = orow * STRIDE_H + int'(oh_q) - PAD;
            assign q    = ocol * STRIDE_L + int'(ol_q) - PAD;

            assign oob[N]   = (r < 0) || (r >= PIC_HEI) || (q < 0) || (q >= PIC_LEN);
            assign lmask[N] = (orow < OUT_H) && (ocol < OUT_L);
            assign mem_addr[N*ADDR_W +: ADDR_W] = oob[N] ? '0 :
                ADDR_W'(int'(c_q) * (PIC_LEN * PIC_HEI) + r * PIC_LEN + q);
        end
    end

    assign w_addr = WA_W'(int'(c_q) * FILT * FILT + int'(ol_q) * FILT + int'(oh_q));

    // Frame sequencer: tap counters nest oh, ol, c, tile col, tile row.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            oh_q    <= '0;
            ol_q    <= '0;
            c_q     <= '0;
            tcol_q  <= '0;
            trow_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // A start coinciding with done is dropped.
                    if (start && !done_q) state_q <= StRun;
                end
                StRun: begin
                    if (issue) begin
                        oh_q <= (oh_q == F_MAX) ? '0 : oh_q + 1'b1;
                        if (oh_q == F_MAX) begin
                            ol_q <= (ol_q == F_MAX) ? '0 : ol_q + 1'b1;
                            if (ol_q == F_MAX) begin
                                c_q <= (c_q == C_MAX) ? '0 : c_q + 1'b1;
                                if (c_q == C_MAX) begin
                                    tcol_q <= (tcol_q == TC_MAX) ? '0 : tcol_q + 1'b1;
                                    if (tcol_q == TC_MAX) begin
                                        trow_q <= (trow_q == TR_MAX) ? '0 : trow_q + 1'b1;
                                    end
                                end
                            end
                        end
                        if (frame_end) state_q <= StFlush;
                    end
                end
                StFlush: begin
                    if (out_valid_q && out_ready && last_q) begin
                        state_q <= StIdle;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Sideband delay and output register; both freeze together with the RAM while stalled.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_first_q   <= 1'b0;
            s1_tap_end_q <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_zero_q    <= '0;
            s1_mask_q    <= '0;
            out_valid_q  <= 1'b0;
            first_tap_q  <= 1'b0;
            last_tap_q   <= 1'b0;
            last_q       <= 1'b0;
            map_q        <= '0;
            weight_q     <= '0;
            lane_mask_q  <= '0;
        end else if (adv) begin
            s1_valid_q   <= issue;
            s1_first_q   <= (oh_q == '0) && (ol_q == '0) && (c_q == '0);
            s1_tap_end_q <= tap_end;
            s1_last_q    <= frame_end;
            s1_zero_q    <= oob | ~lmask;
            s1_mask_q    <= lmask;

            out_valid_q  <= s1_valid_q;
            first_tap_q  <= s1_valid_q && s1_first_q;
            last_tap_q   <= s1_valid_q && s1_tap_end_q;
            last_q       <= s1_valid_q && s1_last_q;
            weight_q     <= s1_valid_q ? w_data : '0;
            lane_mask_q  <= s1_valid_q ? s1_mask_q : '0;
            for (int n = 0; n < LANES; n++) begin
                map_q[n*BITS +: BITS] <= (s1_valid_q && !s1_zero_q[n]) ?
                                         mem_data[n*BITS +: BITS] : '0;
            end
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign first_tap = first_tap_q;
    assign last_tap  = last_tap_q;
    assign last      = last_q;
    assign map       = map_q;
    assign weight    = weight_q;
    assign lane_mask = lane_mask_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: a default-size instance and a small padded two-channel
// instance with a partial last tile column, both checked against an index-arithmetic model.
module tb_conv_window_feeder;

    localparam int LANES  = 16;
    localparam int BITS   = 16;
    localparam int ADDR_W = 15;
    localparam int W_BITS = 64;
    localparam int WA_W   = 5;

    typedef struct {
        int ch;
        int len;
        int hei;
        int filt;
        int st;
        int pad;
    } cfg_t;

    logic clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic rst_n, start, ready, sel;
    int   checks = 0;
    int   errors = 0;
    cfg_t cfg_a, cfg_b;

    logic                    a_start, a_ready, a_busy, a_done, a_mem_en, a_valid;
    logic                    a_first, a_ltap, a_last;
    logic [LANES*ADDR_W-1:0] a_mem_addr;
    logic [LANES*BITS-1:0]   a_mem_data, a_map;
    logic [WA_W-1:0]         a_w_addr;
    logic [W_BITS-1:0]       a_w_data, a_weight;
    logic [LANES-1:0]        a_mask;

    logic                    b_start, b_ready, b_busy, b_done, b_mem_en, b_valid;
    logic                    b_first, b_ltap, b_last;
    logic [LANES*ADDR_W-1:0] b_mem_addr;
    logic [LANES*BITS-1:0]   b_mem_data, b_map;
    logic [WA_W-1:0]         b_w_addr;
    logic [W_BITS-1:0]       b_w_data, b_weight;
    logic [LANES-1:0]        b_mask;

    conv_window_feeder u_dut_a (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (a_start),
        .busy      (a_busy),
        .done      (a_done),
        .mem_en    (a_mem_en),
        .mem_addr  (a_mem_addr),
        .mem_data  (a_mem_data),
        .w_addr    (a_w_addr),
        .w_data    (a_w_data),
        .map       (a_map),
        .weight    (a_weight),
        .out_valid (a_valid),
        .out_ready (a_ready),
        .lane_mask (a_mask),
        .first_tap (a_first),
        .last_tap  (a_ltap),
        .last      (a_last)
    );

    conv_window_feeder #(
        .CH_NUM   (2),
        .PIC_LEN  (9),
        .PIC_HEI  (8),
        .FILT     (3),
        .STRIDE_H (1),
        .STRIDE_L (1),
        .PAD      (1)
    ) u_dut_b (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .start     (b_start),
        .busy      (b_busy),
        .done      (b_done),
        .mem_en    (b_mem_en),
        .mem_addr  (b_mem_addr),
        .mem_data  (b_mem_data),
        .w_addr    (b_w_addr),
        .w_data    (b_w_data),
        .map       (b_map),
        .weight    (b_weight),
        .out_valid (b_valid),
        .out_ready (b_ready),
        .lane_mask (b_mask),
        .first_tap (b_first),
        .last_tap  (b_ltap),
        .last      (b_last)
    );

    assign a_start = sel ? 1'b0 : start;
    assign b_start = sel ? start : 1'b0;
    assign a_ready = sel ? 1'b1 : ready;
    assign b_ready = sel ? ready : 1'b1;

    logic                  o_valid, o_busy, o_done, o_mem_en;
    logic [LANES*BITS-1:0] o_map;
    logic [W_BITS-1:0]     o_weight;
    logic [LANES-1:0]      o_mask;
    logic [2:0]            o_flags;

    assign o_valid  = sel ? b_valid : a_valid;
    assign o_busy   = sel ? b_busy : a_busy;
    assign o_done   = sel ? b_done : a_done;
    assign o_mem_en = sel ? b_mem_en : a_mem_en;
    assign o_map    = sel ? b_map : a_map;
    assign o_weight = sel ? b_weight : a_weight;
    assign o_mask   = sel ? b_mask : a_mask;
    assign o_flags  = sel ? {b_first, b_ltap, b_last} : {a_first, a_ltap, a_last};

    // Picture contents are an odd-multiplier hash of the address, so every address reads distinct.
    function automatic logic [BITS-1:0] ramf(input int a);
        return BITS'(a * 40503 + 12345);
    endfunction

    function automatic logic [W_BITS-1:0] wf(input int a);
        return {16'(a * 3 + 101), 16'(a * 5 + 7), 16'(a ^ 'hBEEF), 16'(a + 1)};
    endfunction

    always @(posedge clk_in) begin
        if (a_mem_en) begin
            for (int n = 0; n < LANES; n++)
                a_mem_data[n*BITS +: BITS] <= ramf(int'(a_mem_addr[n*ADDR_W +: ADDR_W]));
            a_w_data <= wf(int'(a_w_addr));
        end
        if (b_mem_en) begin
            for (int n = 0; n < LANES; n++)
                b_mem_data[n*BITS +: BITS] <= ramf(int'(b_mem_addr[n*ADDR_W +: ADDR_W]));
            b_w_data <= wf(int'(b_w_addr));
        end
    end

    function automatic int frame_beats(input cfg_t cf);
        int out_h, out_l;
        out_h = (cf.hei + 2 * cf.pad - cf.filt) / cf.st + 1;
        out_l = (cf.len + 2 * cf.pad - cf.filt) / cf.st + 1;
        return ((out_h + 3) / 4) * ((out_l + 3) / 4) * cf.ch * cf.filt * cf.filt;
    endfunction

    // Expected beat number idx of a frame, decoded straight from the beat index.
    function automatic void model(input cfg_t cf, input int idx,
                                  output logic [LANES*BITS-1:0] m, output logic [W_BITS-1:0] w,
                                  output logic [LANES-1:0] mk, output logic [2:0] fl);
        int out_h, out_l, tc, taps, per_tile, t, tap, trow, tcol, c, ol, oh;
        int orow, ocol, r, q, n;
        out_h    = (cf.hei + 2 * cf.pad - cf.filt) / cf.st + 1;
        out_l    = (cf.len + 2 * cf.pad - cf.filt) / cf.st + 1;
        tc       = (out_l + 3) / 4;
        taps     = cf.filt * cf.filt;
        per_tile = cf.ch * taps;
        t        = idx / per_tile;
        tap      = idx % per_tile;
        trow     = t / tc;
        tcol     = t % tc;
        c        = tap / taps;
        ol       = (tap % taps) / cf.filt;
        oh       = (tap % taps) % cf.filt;
        m  = '0;
        mk = '0;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < 4; k++) begin
                n     = j * 4 + k;
                orow  = trow * 4 + j;
                ocol  = tcol * 4 + k;
                r     = orow * cf.st + oh - cf.pad;
                q     = ocol * cf.st + ol - cf.pad;
                mk[n] = (orow < out_h) && (ocol < out_l);
                if (mk[n] && r >= 0 && r < cf.hei && q >= 0 && q < cf.len)
                    m[n*BITS +: BITS] = ramf(c * cf.len * cf.hei + r * cf.len + q);
            end
        end
        w  = wf(tap);
        fl = {tap == 0, tap == per_tile - 1, idx == frame_beats(cf) - 1};
    endfunction

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // Runs one frame (or stops after abort_at accepted beats), checking every valid cycle.
    task automatic run_frame(input cfg_t cf, input bit sel_v, input bit rand_ready,
                             input bit hold_start, input int abort_at);
        int                    total, idx, n, budget;
        bit                    got_done, seen_first, last_acc, rdy;
        logic [LANES*BITS-1:0] em;
        logic [W_BITS-1:0]     ew;
        logic [LANES-1:0]      emk;
        logic [2:0]            efl;
        total      = frame_beats(cf);
        budget     = total * 4 + 100;
        idx        = 0;
        n          = 0;
        got_done   = 0;
        seen_first = 0;
        last_acc   = 0;
        sel        = sel_v;
        @(negedge clk_in);
        start = 1'b1;
        ready = 1'b1;
        while (!got_done && n < budget) begin
            @(negedge clk_in);
            n++;
            if (!hold_start) start = 1'b0;
            if (abort_at >= 0 && idx >= abort_at) break;
            if (o_valid) begin
                if (!seen_first) begin
                    seen_first = 1;
                    check_eq("first_latency", n, 3);
                    check_eq("busy_run", o_busy, 1);
                end
                if (idx >= total) begin
                    check_eq("extra_beat", idx, total - 1);
                end else begin
                    model(cf, idx, em, ew, emk, efl);
                    check_eq("map", o_map, em);
                    check_eq("weight", o_weight, ew);
                    check_eq("lane_mask", o_mask, emk);
                    check_eq("flags", o_flags, efl);
                end
            end
            if (o_done || last_acc) check_eq("done_pulse", o_done, last_acc);
            if (o_done) begin
                got_done = 1;
                check_eq("beat_count", idx, total);
                check_eq("busy_at_done", o_busy, 0);
            end
            rdy      = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            ready    = rdy;
            last_acc = o_valid && rdy && (idx == total - 1);
            if (o_valid && rdy) idx++;
        end
        if (!got_done && abort_at < 0) check_eq("frame_timeout", got_done, 1);
    endtask

    initial begin
        cfg_a = '{ch: 1, len: 100, hei: 252, filt: 5, st: 4, pad: 0};
        cfg_b = '{ch: 2, len: 9, hei: 8, filt: 3, st: 1, pad: 1};
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        sel   = 1'b0;
        repeat (3) @(negedge clk_in);
        check_eq("rst_valid", o_valid, 0);
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_mem_en", o_mem_en, 0);
        check_eq("rst_map", o_map, 0);
        check_eq("rst_weight", o_weight, 0);
        check_eq("rst_mask", o_mask, 0);
        check_eq("rst_flags", o_flags, 0);
        rst_n = 1'b1;

        run_frame(cfg_a, 1'b0, 1'b0, 1'b0, -1);
        run_frame(cfg_a, 1'b0, 1'b1, 1'b0, -1);
        run_frame(cfg_b, 1'b1, 1'b0, 1'b0, -1);
        run_frame(cfg_b, 1'b1, 1'b1, 1'b0, -1);

        // Mid-frame reset, then a fresh complete frame.
        run_frame(cfg_a, 1'b0, 1'b0, 1'b0, 500);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", o_valid, 0);
        check_eq("mid_rst_busy", o_busy, 0);
        check_eq("mid_rst_mem_en", o_mem_en, 0);
        check_eq("mid_rst_map", o_map, 0);
        check_eq("mid_rst_weight", o_weight, 0);
        check_eq("mid_rst_mask", o_mask, 0);
        check_eq("mid_rst_flags", o_flags, 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        run_frame(cfg_a, 1'b0, 1'b0, 1'b0, -1);

        // Start held through the frame and the done cycle: no second frame may begin.
        run_frame(cfg_a, 1'b0, 1'b0, 1'b1, -1);
        @(negedge clk_in);
        check_eq("held_start_ignored", o_busy, 0);
        start = 1'b0;
        repeat (4) begin
            @(negedge clk_in);
            check_eq("idle_after_held", {o_busy, o_valid}, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
